// File: rtl/code_entry_pkg.sv
// Shared encodings and defaults for the product-code entry controller.
package code_entry_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOCKED = 2'd2
    } fsm_state_t;

    // Machine-level state in which code entry is permitted.
    localparam logic [2:0]  ENTRY_STATE_DEFAULT = 3'd1;
    localparam int unsigned DIGIT_W_DEFAULT     = 4;
    localparam int unsigned RADIX_DEFAULT       = 10;

endpackage

// File: rtl/code_entry_ctrl_digit_counter.sv
// Single selection digit: modulo-RADIX counter, synchronous clear wins over enable.
module digit_counter #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned RADIX   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(RADIX - 1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LAST) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/code_entry_ctrl.sv
// Product-code entry controller: button edge detection, per-digit counters,
// and an IDLE/ENTRY/LOCKED FSM presenting the confirmed code under valid/ack.
module code_entry_ctrl
    import code_entry_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned DIGIT_W     = DIGIT_W_DEFAULT,
    parameter int unsigned RADIX       = RADIX_DEFAULT,
    parameter int unsigned OUT_W       = 16,
    parameter logic [2:0]  ENTRY_STATE = ENTRY_STATE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  switch,
    input  logic [2:0]            state,
    input  logic [NUM_DIGITS-1:0] inc,
    input  logic                  clear,
    input  logic                  confirm,
    input  logic                  code_ack,
    output logic [OUT_W-1:0]      code_out,
    output logic                  code_valid,
    output logic                  entry_active
);

    fsm_state_t            fsm;
    logic [NUM_DIGITS-1:0] inc_q;
    logic                  clear_q;
    logic                  confirm_q;
    logic [NUM_DIGITS-1:0] inc_p;
    logic                  clear_p;
    logic                  confirm_p;
    logic                  entry_en;
    logic                  any_nonzero;
    logic                  accept;
    logic                  digit_clr;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [DIGIT_W-1:0]    digit [NUM_DIGITS];

    // Loading current levels even during reset means a held button never pulses.
    always_ff @(posedge clk) begin
        inc_q     <= inc;
        clear_q   <= clear;
        confirm_q <= confirm;
    end

    assign inc_p     = inc & ~inc_q;
    assign clear_p   = clear & ~clear_q;
    assign confirm_p = confirm & ~confirm_q;
    assign entry_en  = switch && (state == ENTRY_STATE);

    always_comb begin
        any_nonzero = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            any_nonzero = any_nonzero | (digit[i] != '0);
        end
    end

    assign accept = confirm_p && any_nonzero;

    // Priority in ENTRY: leaving entry > clear > accepted confirm > increments.
    always_comb begin
        digit_clr = 1'b0;
        digit_en  = '0;
        case (fsm)
            IDLE:   digit_clr = 1'b1;
            ENTRY: begin
                if (!entry_en || clear_p) begin
                    digit_clr = 1'b1;
                end else if (!accept) begin
                    digit_en = inc_p;
                end
            end
            LOCKED: digit_clr = code_ack;
            default: digit_clr = 1'b1;
        endcase
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        digit_counter #(
            .DIGIT_W(DIGIT_W),
            .RADIX  (RADIX)
        ) u_digit (
            .clk  (clk),
            .reset(reset),
            .clr  (digit_clr),
            .en   (digit_en[g]),
            .q    (digit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm          <= IDLE;
            code_valid   <= 1'b0;
            entry_active <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (entry_en) begin
                        fsm          <= ENTRY;
                        entry_active <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (!entry_en) begin
                        fsm          <= IDLE;
                        entry_active <= 1'b0;
                    end else if (!clear_p && accept) begin
                        fsm          <= LOCKED;
                        entry_active <= 1'b0;
                        code_valid   <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (code_ack) begin
                        fsm        <= IDLE;
                        code_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm          <= IDLE;
                    code_valid   <= 1'b0;
                    entry_active <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        code_out = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            code_out[DIGIT_W*i +: DIGIT_W] = digit[i];
        end
    end

endmodule

// File: doc/code_entry_ctrl.md
Name: code_entry_ctrl

Overview:
- Parametrised product-code entry controller for the vending machine, clocked by a single `clk`.
- Holds NUM_DIGITS selection digits. Each digit advances modulo RADIX on the rising edge of its own button input.
- The customer confirms the code; the block then presents it to the price-lookup stage under a valid/ack handshake.
- Replaces the per-digit clocked code counters: the buttons are now data inputs sampled on one clock, not clocks.

Parameters:
- NUM_DIGITS, 2, number of code digits.
- DIGIT_W, 4, bits per digit.
- RADIX, 10, digit modulus (wraps RADIX-1 -> 0). Constraint: RADIX <= 2**DIGIT_W.
- OUT_W, 16, width of code_out. Constraint: NUM_DIGITS*DIGIT_W <= OUT_W.
- ENTRY_STATE, 3'd1, machine state value in which code entry is permitted.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- switch  input  1  entry enable switch (level).
- state  input  3  vending machine state.
- inc  input  NUM_DIGITS  per-digit increment buttons (level); bit i drives digit i.
- clear  input  1  clear-entry button (level).
- confirm  input  1  confirm button (level).
- code_ack  input  1  downstream consumed the code (level, sampled only in LOCKED).
- code_out  output  OUT_W  packed code; digit i at [DIGIT_W*i +: DIGIT_W], digit NUM_DIGITS-1 most significant; bits above NUM_DIGITS*DIGIT_W are 0.
- code_valid  output  1  code_out is a confirmed code.
- entry_active  output  1  FSM in ENTRY.

Behaviour:
- Edge detect:
  - Registered copies inc_q, clear_q and confirm_q.
  - pulse = level & ~level_q, evaluated combinationally.
  - On reset, the _q registers load the current input levels, so a button held through reset produces no pulse.
- Entry enable: entry_en = switch && (state == ENTRY_STATE).
- FSM states: IDLE, ENTRY, LOCKED.
- Reset (synchronous):
  - FSM -> IDLE.
  - All digits = 0, code_out = 0, code_valid = 0, entry_active = 0.
  - Reset overrides every other event in the same cycle, including reset asserted mid-entry or in LOCKED.
- IDLE:
  - Digits held at 0.
  - entry_en=1 -> ENTRY on the next edge. Pulses arriving in that same cycle are ignored.
- ENTRY:
  - inc pulse on bit i -> digit i += 1 mod RADIX at that edge; code_out reflects it 1 cycle after inc rises.
  - Several bits pulsing in the same cycle update independently.
  - clear pulse -> all digits 0. clear has priority over inc and confirm in the same cycle.
  - confirm pulse with at least one nonzero digit -> LOCKED; code_valid=1 from the next cycle.
  - confirm with all digits 0 is ignored (code 0 is not a product).
  - inc pulse in the same cycle as an accepted confirm is ignored; the code locks with pre-increment digits.
  - entry_en=0 -> IDLE with digits cleared. This has priority over clear, confirm and inc.
- LOCKED:
  - Digits frozen; inc, clear and confirm are ignored; code_valid=1.
  - entry_en changes are ignored; the code is held until acked.
  - code_ack=1 -> IDLE at that edge: digits 0, code_valid=0.
  - ack is level-sensitive, so an ack already high on entry to LOCKED completes after exactly one cycle of code_valid.
- code_ack outside LOCKED has no effect.
- Outputs are registered or decoded directly from state and digit registers; there is no combinational path from inputs to outputs.

Decomposition:
- Package code_entry_pkg:
  - FSM state encoding: IDLE=2'd0, ENTRY=2'd1, LOCKED=2'd2.
  - Default ENTRY_STATE constant, shared with the machine-level FSM.
  - Default RADIX and DIGIT_W.
- Sub-module digit_counter (parameters DIGIT_W, RADIX), instantiated NUM_DIGITS times by generate:
  - Inputs: clk, reset, clr, en.
  - Output: q.
  - Behaviour: modulo-RADIX counter with synchronous clear taking priority over en.
- Edge detectors and FSM live in the top level.

Test Plan:
1. Reset, switch=1, state=ENTRY_STATE; pulse inc[0] three times, inc[1] once; pulse confirm -> code_out=16'h0013 one cycle after the last inc; code_valid=1 the cycle after confirm.
2. In ENTRY, pulse inc[0] 10 times -> digit 0 sequence 1..9, then 0 (wrap). With NUM_DIGITS=3, DIGIT_W=4, RADIX=16, pulsing inc[2] 17 times gives code_out=16'h0100.
3. confirm with digits 00 -> stays ENTRY, code_valid=0. Same cycle: inc[0] and clear pulse -> digits remain 0.
4. Lock code 0x0025; toggle inc, clear, confirm and switch -> code_out stays 0x0025 and code_valid stays 1. Assert code_ack -> next cycle code_valid=0, code_out=0, FSM IDLE.
5. Hold inc[1]=1 across reset deassertion -> no increment. Assert reset while LOCKED -> next cycle all outputs 0.
6. Switch drops mid-entry with digits 0x0047 -> IDLE, code_out=0. Switch re-raised -> entry restarts from 0x0000.
